color_cmd_driver: RTL and testbench

COLOR_CMD_DRIVER -- requirements
Module: color_cmd_driver

---
 rtl/color_cmd_driver.sv | 158 +++++++++++++++
 tb/tb_color_cmd_driver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/color_cmd_driver.sv
// color_cmd_driver
//   Steers an external two-colour FSM (Blue/Red) to a requested colour.
//   A request is accepted in IDLE. If the FSM already shows the target
//   colour the driver finishes at once. Otherwise it sends one toggle
//   command and waits for the status to follow. After TIMEOUT cycles
//   without a match it re-sends the toggle, up to MAX_RETRY times, and
//   then reports an error. An illegal status code ends the transaction
//   with an error straight away.
//
// Parameters
//   TIMEOUT    cycles spent in WAIT before a retry (1..15)
//   MAX_RETRY  re-issues allowed after the first toggle (0..7)
//
// Ports
//   clk           clock, all state changes on posedge
//   rst           asynchronous active-low reset
//   req_valid     requester offers a target colour
//   req_color     target colour: 0 = Blue, 1 = Red
//   req_ready     high only in IDLE (and therefore during reset)
//   cmd           to colour FSM: 2'h1 = toggle, 2'h0 = hold
//   status        colour FSM code: 2'h1 = Blue, 2'h2 = Red, others illegal
//   done_valid    one-cycle completion pulse
//   done_err      failure flag, qualified by done_valid
//   toggle_count  toggles issued since reset, saturating at 8'hFF
module color_cmd_driver #(
  parameter int TIMEOUT   = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_color,
  output logic       req_ready,
  output logic [1:0] cmd,
  input  logic [1:0] status,
  output logic       done_valid,
  output logic       done_err,
  output logic [7:0] toggle_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] TIMER_LAST = 4'(TIMEOUT - 1);
  localparam logic [2:0] RETRY_MAX  = 3'(MAX_RETRY);

  state_t     state_reg, state_next;
  logic       target_reg, target_next;
  logic [3:0] timer_reg, timer_next;
  logic [2:0] retry_reg, retry_next;
  logic       err_reg, err_next;
  logic [7:0] count_reg, count_next;

  // The colour codes are one-hot: Blue = 2'b01, Red = 2'b10, so a colour
  // bit c maps to {c, ~c}. Both bits equal means an illegal code.
  logic       status_illegal;
  logic [1:0] code_req;
  logic [1:0] code_target;

  assign status_illegal = (status[1] == status[0]);
  assign code_req       = {req_color, ~req_color};
  assign code_target    = {target_reg, ~target_reg};

  assign toggle_count   = count_reg;

  // State and datapath registers. Because every output below is decoded
  // from these registers, reset forces the outputs immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      target_reg <= 1'b0;
      timer_reg  <= 4'd0;
      retry_reg  <= 3'd0;
      err_reg    <= 1'b0;
      count_reg  <= 8'd0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
      timer_reg  <= timer_next;
      retry_reg  <= retry_next;
      err_reg    <= err_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    timer_next  = timer_reg;
    retry_next  = retry_reg;
    err_next    = err_reg;
    count_next  = count_reg;
    req_ready   = 1'b0;
    cmd         = 2'h0;
    done_valid  = 1'b0;
    done_err    = 1'b0;

    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          target_next = req_color;
          retry_next  = 3'd0;
          // Decide against the incoming colour, not the stale target.
          if (status == code_req) begin
            err_next   = 1'b0;
            state_next = DONE;
          end else if (status_illegal) begin
            err_next   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = ISSUE;
          end
        end
      end

      ISSUE: begin
        cmd        = 2'h1;
        timer_next = 4'd0;
        if (count_reg != 8'hFF) begin
          count_next = count_reg + 8'd1;
        end
        state_next = WAIT;
      end

      WAIT: begin
        // A match wins even on the last timer cycle.
        if (status == code_target) begin
          err_next   = 1'b0;
          state_next = DONE;
        end else if (status_illegal) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else if (timer_reg == TIMER_LAST) begin
          if (retry_reg < RETRY_MAX) begin
            retry_next = retry_reg + 3'd1;
            state_next = ISSUE;
          end else begin
            err_next   = 1'b1;
            state_next = DONE;
          end
        end else begin
          timer_next = timer_reg + 4'd1;
        end
      end

      DONE: begin
        done_valid = 1'b1;
        done_err   = err_reg;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_color_cmd_driver.sv
// tb_color_cmd_driver
//   Self-checking bench for color_cmd_driver. The bench plays the colour
//   FSM: it drives status cycle by cycle from a per-transaction scenario
//   (status flips to the target, or to an illegal code, a chosen number of
//   cycles after a chosen toggle, or never flips). Expected completion
//   cycle, error flag, toggle cycles and toggle_count come from a
//   closed-form transaction model or from hand-written table entries.
module tb_color_cmd_driver;

  localparam int T  = 4;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_color = 1'b0;
  logic       req_ready;
  logic [1:0] cmd;
  logic [1:0] status = 2'h1;
  logic       done_valid;
  logic       done_err;
  logic [7:0] toggle_count;

  always #5 clk = ~clk;

  color_cmd_driver #(.TIMEOUT(T), .MAX_RETRY(MR)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_color    (req_color),
    .req_ready    (req_ready),
    .cmd          (cmd),
    .status       (status),
    .done_valid   (done_valid),
    .done_err     (done_err),
    .toggle_count (toggle_count)
  );

  // kind 0: status becomes the target code d cycles after toggle k
  // kind 1: status never changes
  // kind 2: status becomes 2'h3 d cycles after toggle k
  typedef struct {
    logic       color;
    logic [1:0] s0;
    int         kind;
    int         k;
    int         d;
    int         exp_done;
    logic       exp_err;
    int         exp_tog;
  } vec_t;

  vec_t vecs[11];
  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   tc_model = 0;
  int   txn_id   = 0;

  function automatic logic [1:0] code_of(input logic c);
    return {c, ~c};
  endfunction

  // Cycle (relative to acceptance = 0) in which the i-th toggle (1-based)
  // is on cmd: the first right after acceptance, then one every T+1.
  function automatic int toggle_cycle(input int i);
    return 1 + (i - 1) * (T + 1);
  endfunction

  function automatic logic [1:0] status_at(input vec_t v, input int c);
    if (v.kind == 1) return v.s0;
    if (c >= toggle_cycle(v.k) + v.d) return (v.kind == 0) ? code_of(v.color) : 2'h3;
    return v.s0;
  endfunction

  // Transaction-level reference: outcome from the request and scenario.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    if (v.s0 == 2'h0 || v.s0 == 2'h3) begin
      r.exp_done = 1; r.exp_err = 1'b1; r.exp_tog = 0;
    end else if (v.s0 == code_of(v.color)) begin
      r.exp_done = 1; r.exp_err = 1'b0; r.exp_tog = 0;
    end else if (v.kind == 1) begin
      r.exp_tog  = MR + 1;
      r.exp_done = toggle_cycle(MR + 1) + T + 1;
      r.exp_err  = 1'b1;
    end else begin
      r.exp_tog  = v.k;
      r.exp_done = toggle_cycle(v.k) + v.d + 1;
      r.exp_err  = (v.kind == 2);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (txn %0d): got %0h, expected %0h", name, txn_id, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    logic [63:0] act_mask, exp_mask;
    int   done_at, busy_ready, stray_err, bad_cmd;
    logic err_seen;
    exp_mask = '0;
    for (int i = 1; i <= v.exp_tog; i++) exp_mask[toggle_cycle(i)] = 1'b1;
    act_mask = '0; done_at = -1; err_seen = 1'b0;
    busy_ready = 0; stray_err = 0; bad_cmd = 0;
    txn_id++;

    @(negedge clk);
    check("idle_outputs", {59'd0, req_ready, cmd, done_valid, done_err}, {59'd0, 1'b1, 2'h0, 1'b0, 1'b0});
    req_valid = 1'b1;
    req_color = v.color;
    status    = v.s0;

    for (int c = 1; c < 48 && done_at < 0; c++) begin
      @(negedge clk);
      if (cmd != 2'h0) act_mask[c] = 1'b1;
      if (cmd != 2'h0 && cmd != 2'h1) bad_cmd++;
      if (req_ready) busy_ready++;
      if (done_valid) begin
        done_at  = c;
        err_seen = done_err;
      end else if (done_err) begin
        stray_err++;
      end
      status = status_at(v, c);
      // Noise on the request lines while busy must be ignored.
      req_valid = (done_at < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_color = 1'($urandom_range(0, 1));
    end
    req_valid = 1'b0;

    tc_model = (tc_model + v.exp_tog > 255) ? 255 : tc_model + v.exp_tog;
    check("done_cycle",   64'(done_at),    64'(v.exp_done));
    check("done_err",     {63'd0, err_seen}, {63'd0, v.exp_err});
    check("cmd_pulses",   act_mask,        exp_mask);
    check("toggle_count", {56'd0, toggle_count}, 64'(tc_model));
    check("busy_ready",   64'(busy_ready), 64'd0);
    check("stray_err",    64'(stray_err),  64'd0);
    check("bad_cmd",      64'(bad_cmd),    64'd0);
    $display("txn %0d: color=%0d s0=%0h kind=%0d k=%0d d=%0d -> done@%0d err=%0b toggles=%0d count=%0d",
             txn_id, v.color, v.s0, v.kind, v.k, v.d, done_at, err_seen, v.exp_tog, toggle_count);
  endtask

  // Start a stuck Red request, pull reset after 'cycles_in' cycles.
  task automatic reset_mid(input int cycles_in, input string name);
    txn_id++;
    @(negedge clk);
    req_valid = 1'b1; req_color = 1'b1; status = 2'h1;
    for (int c = 1; c <= cycles_in; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    check({name, "_pre_cmd"}, {62'd0, cmd}, (cycles_in == 1) ? 64'd1 : 64'd0);
    rst = 1'b0;
    #1;
    check({name, "_async"}, {52'd0, cmd, req_ready, done_valid, done_err, toggle_count},
          {52'd0, 2'h0, 1'b1, 1'b0, 1'b0, 8'h00});
    tc_model = 0;
    repeat (2) begin
      @(negedge clk);
      check({name, "_held"}, {60'd0, done_valid, req_ready, cmd}, {60'd0, 1'b0, 1'b1, 2'h0});
    end
    rst = 1'b1;
    @(negedge clk);
    check({name, "_release"}, {53'd0, req_ready, done_valid, cmd, toggle_count},
          {53'd0, 1'b1, 1'b0, 2'h0, 8'h00});
    $display("txn %0d: reset after %0d cycles (%s)", txn_id, cycles_in, name);
  endtask

  initial begin
    vec_t v;

    // color, s0, kind, k, d, exp_done, exp_err, exp_tog
    vecs[0]  = '{1'b1, 2'h1, 0, 1, 1,  3, 1'b0, 1};  // normal toggle
    vecs[1]  = '{1'b1, 2'h2, 1, 1, 1,  1, 1'b0, 0};  // already Red
    vecs[2]  = '{1'b1, 2'h1, 1, 1, 1, 16, 1'b1, 3};  // stuck, retries exhausted
    vecs[3]  = '{1'b0, 2'h2, 2, 1, 1,  3, 1'b1, 1};  // illegal in WAIT
    vecs[4]  = '{1'b0, 2'h1, 1, 1, 1,  1, 1'b0, 0};  // already Blue
    vecs[5]  = '{1'b0, 2'h0, 1, 1, 1,  1, 1'b1, 0};  // illegal at accept
    vecs[6]  = '{1'b1, 2'h3, 1, 1, 1,  1, 1'b1, 0};  // illegal at accept
    vecs[7]  = '{1'b0, 2'h2, 0, 1, 4,  6, 1'b0, 1};  // match on last timer cycle
    vecs[8]  = '{1'b1, 2'h1, 0, 3, 4, 16, 1'b0, 3};  // match on last retry, last cycle
    vecs[9]  = '{1'b0, 2'h2, 0, 2, 2,  9, 1'b0, 2};  // match after one retry
    vecs[10] = '{1'b1, 2'h1, 2, 3, 2, 14, 1'b1, 3};  // illegal after last retry

    // Reset applied before any clock edge.
    #2 rst = 1'b0;
    #1;
    check("reset_state", {52'd0, req_ready, cmd, done_valid, done_err, toggle_count},
          {52'd0, 1'b1, 2'h0, 1'b0, 1'b0, 8'h00});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_release", {63'd0, req_ready}, 64'd1);

    for (int i = 0; i < 11; i++) run_txn(vecs[i]);

    for (int i = 0; i < 80; i++) begin
      v.color = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       v.s0 = $urandom_range(0, 1) ? 2'h3 : 2'h0;
        1:       v.s0 = code_of(v.color);
        default: v.s0 = code_of(~v.color);
      endcase
      v.kind = $urandom_range(0, 2);
      v.k    = $urandom_range(1, MR + 1);
      v.d    = $urandom_range(1, T);
      v      = model(v);
      run_txn(v);
    end

    // Drive toggle_count into saturation.
    v = '{1'b1, 2'h1, 0, 1, 1, 0, 1'b0, 0};
    v = model(v);
    for (int i = 0; i < 300; i++) run_txn(v);
    check("count_saturated", {56'd0, toggle_count}, 64'hFF);

    reset_mid(1, "reset_in_issue");
    reset_mid(3, "reset_in_wait");
    run_txn(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
